syn_gpu_fill_rect: RTL and testbench

//  Rectangle fill engine in the GPU core, directly upstream of the pixel gateway (posx/posy -> SRAM addr stage).

---
 rtl/syn_gpu_pkg.sv | 26 ++
 rtl/syn_gpu_fill_clip.sv | 32 +++
 rtl/syn_gpu_fill_rect.sv | 128 ++++++++++++
 tb/tb_syn_gpu_fill_rect.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/syn_gpu_pkg.sv
// Shared GPU types: HSI pixel, rectangle fill command and fill engine state.
package syn_gpu_pkg;

  localparam int P_X_W      = 10;
  localparam int P_Y_W      = 9;
  localparam int P_PXL_W    = 8;
  localparam int P_CANVAS_W = 640;
  localparam int P_CANVAS_H = 480;

  typedef logic [P_PXL_W-1:0] pxl_hsi_t;

  typedef struct packed {
    logic [P_X_W-1:0] x0;
    logic [P_Y_W-1:0] y0;
    logic [P_X_W-1:0] w;
    logic [P_Y_W-1:0] h;
    pxl_hsi_t         pxl;
  } fill_cmd_t;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_fsm_t;

endpackage

// File: rtl/syn_gpu_fill_clip.sv
// Combinational clip of a fill command to the canvas; an origin off the canvas
// yields an empty (w=h=0) rectangle.
module syn_gpu_fill_clip #(
  parameter int P_CANVAS_W = syn_gpu_pkg::P_CANVAS_W,
  parameter int P_CANVAS_H = syn_gpu_pkg::P_CANVAS_H
) (
  input  syn_gpu_pkg::fill_cmd_t cmd_i,
  output syn_gpu_pkg::fill_cmd_t cmd_o
);
  import syn_gpu_pkg::*;

  logic             off_canvas;
  logic [P_X_W:0]   room_x;
  logic [P_Y_W:0]   room_y;

  assign off_canvas = (int'(cmd_i.x0) >= P_CANVAS_W) || (int'(cmd_i.y0) >= P_CANVAS_H);
  assign room_x     = (P_X_W+1)'(P_CANVAS_W) - {1'b0, cmd_i.x0};
  assign room_y     = (P_Y_W+1)'(P_CANVAS_H) - {1'b0, cmd_i.y0};

  always_comb begin
    cmd_o = cmd_i;
    if (off_canvas) begin
      cmd_o.w = '0;
      cmd_o.h = '0;
    end else begin
      // room is at most the canvas size here, so it fits the field width
      if ({1'b0, cmd_i.w} > room_x) cmd_o.w = room_x[P_X_W-1:0];
      if ({1'b0, cmd_i.h} > room_y) cmd_o.h = room_y[P_Y_W-1:0];
    end
  end

endmodule

// File: rtl/syn_gpu_fill_rect.sv
// Rectangle fill engine: one command in, raster-order pixel writes out over the
// valid/ready gateway handshake. Define SYN_GPU_FILL_CLIP_EN to clip to the canvas.
module syn_gpu_fill_rect #(
  parameter int P_X_W      = syn_gpu_pkg::P_X_W,
  parameter int P_Y_W      = syn_gpu_pkg::P_Y_W,
  parameter int P_PXL_W    = syn_gpu_pkg::P_PXL_W,
  parameter int P_CANVAS_W = syn_gpu_pkg::P_CANVAS_W,
  parameter int P_CANVAS_H = syn_gpu_pkg::P_CANVAS_H
) (
  input  logic               clk_ir,
  input  logic               rst_sync,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [P_X_W-1:0]   cmd_x0,
  input  logic [P_Y_W-1:0]   cmd_y0,
  input  logic [P_X_W-1:0]   cmd_w,
  input  logic [P_Y_W-1:0]   cmd_h,
  input  logic [P_PXL_W-1:0] cmd_pxl,
  output logic [P_PXL_W-1:0] pxl,
  output logic               pxl_wr_valid,
  output logic               pxl_rd_valid,
  output logic [P_X_W-1:0]   posx,
  output logic [P_Y_W-1:0]   posy,
  input  logic               ready,
  output logic               busy,
  output logic               fill_done
);
  import syn_gpu_pkg::*;

  fill_cmd_t cmd_in, cmd_eff;

  assign cmd_in = '{x0: cmd_x0, y0: cmd_y0, w: cmd_w, h: cmd_h, pxl: cmd_pxl};

`ifdef SYN_GPU_FILL_CLIP_EN
  syn_gpu_fill_clip #(
    .P_CANVAS_W (P_CANVAS_W),
    .P_CANVAS_H (P_CANVAS_H)
  ) u_clip (
    .cmd_i (cmd_in),
    .cmd_o (cmd_eff)
  );
`else
  assign cmd_eff = cmd_in;
`endif

  fill_fsm_t          state_q, state_d;
  logic [P_X_W-1:0]   x0_q, x0_d;
  // one extra bit so the row/column end compare works past the field range
  logic [P_X_W:0]     posx_q, posx_d, x_end_q, x_end_d;
  logic [P_Y_W:0]     posy_q, posy_d, y_end_q, y_end_d;
  logic [P_PXL_W-1:0] pxl_q, pxl_d;

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      state_q <= FILL_IDLE;
      x0_q    <= '0;
      posx_q  <= '0;
      posy_q  <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      pxl_q   <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      pxl_q   <= pxl_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    posx_d       = posx_q;
    posy_d       = posy_q;
    x_end_d      = x_end_q;
    y_end_d      = y_end_q;
    pxl_d        = pxl_q;
    cmd_ready    = 1'b0;
    pxl_wr_valid = 1'b0;
    busy         = 1'b0;
    fill_done    = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          x0_d    = cmd_eff.x0;
          posx_d  = {1'b0, cmd_eff.x0};
          posy_d  = {1'b0, cmd_eff.y0};
          x_end_d = {1'b0, cmd_eff.x0} + {1'b0, cmd_eff.w} - 1'b1;
          y_end_d = {1'b0, cmd_eff.y0} + {1'b0, cmd_eff.h} - 1'b1;
          pxl_d   = cmd_eff.pxl;
          state_d = (cmd_eff.w != '0 && cmd_eff.h != '0) ? FILL_RUN : FILL_DONE;
        end
      end
      FILL_RUN: begin
        pxl_wr_valid = 1'b1;
        busy         = 1'b1;
        if (ready) begin
          if (posx_q == x_end_q) begin
            if (posy_q == y_end_q) begin
              state_d = FILL_DONE;
            end else begin
              posx_d = {1'b0, x0_q};
              posy_d = posy_q + 1'b1;
            end
          end else begin
            posx_d = posx_q + 1'b1;
          end
        end
      end
      FILL_DONE: begin
        busy      = 1'b1;
        fill_done = 1'b1;
        state_d   = FILL_IDLE;
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  assign pxl          = pxl_q;
  assign posx         = posx_q[P_X_W-1:0];
  assign posy         = posy_q[P_Y_W-1:0];
  assign pxl_rd_valid = 1'b0;

endmodule

// File: tb/tb_syn_gpu_fill_rect.sv
// Directed bench for syn_gpu_fill_rect; clip expectations follow SYN_GPU_FILL_CLIP_EN.
module tb_syn_gpu_fill_rect;

  logic       clk_ir = 1'b0;
  logic       rst_sync;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_x0;
  logic [8:0] cmd_y0;
  logic [9:0] cmd_w;
  logic [8:0] cmd_h;
  logic [7:0] cmd_pxl;
  logic [7:0] pxl;
  logic       pxl_wr_valid;
  logic       pxl_rd_valid;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       ready;
  logic       busy;
  logic       fill_done;

  int n_chk  = 0;
  int n_fail = 0;

  syn_gpu_fill_rect dut (
    .clk_ir       (clk_ir),
    .rst_sync     (rst_sync),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x0       (cmd_x0),
    .cmd_y0       (cmd_y0),
    .cmd_w        (cmd_w),
    .cmd_h        (cmd_h),
    .cmd_pxl      (cmd_pxl),
    .pxl          (pxl),
    .pxl_wr_valid (pxl_wr_valid),
    .pxl_rd_valid (pxl_rd_valid),
    .posx         (posx),
    .posy         (posy),
    .ready        (ready),
    .busy         (busy),
    .fill_done    (fill_done)
  );

  always #5 clk_ir = ~clk_ir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command for one cycle, then scramble the fields to show they were captured.
  task automatic send(input int x0, input int y0, input int w, input int h, input int p);
    @(negedge clk_ir);
    chk("cmd_ready_before_accept", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_x0    = 10'(x0);
    cmd_y0    = 9'(y0);
    cmd_w     = 10'(w);
    cmd_h     = 9'(h);
    cmd_pxl   = 8'(p);
    @(negedge clk_ir);
    cmd_valid = 1'b0;
    cmd_x0    = 10'h3ff;
    cmd_y0    = 9'h1ff;
    cmd_w     = 10'h3ff;
    cmd_h     = 9'h1ff;
    cmd_pxl   = 8'h00;
  endtask

  // Expect the pixel currently offered, then let one clock (transfer with ready=1) pass.
  task automatic pix(input string tag, input int x, input int y, input int p);
    chk({tag, "_wr_valid"}, 32'(pxl_wr_valid), 1);
    chk({tag, "_posx"}, 32'(posx), x);
    chk({tag, "_posy"}, 32'(posy), y);
    chk({tag, "_pxl"}, 32'(pxl), p);
    @(negedge clk_ir);
  endtask

  task automatic done_chk(input string tag);
    chk({tag, "_done_wr_valid"}, 32'(pxl_wr_valid), 0);
    chk({tag, "_done_pulse"}, 32'(fill_done), 1);
    chk({tag, "_done_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_done_busy"}, 32'(busy), 1);
    @(negedge clk_ir);
    chk({tag, "_idle_done"}, 32'(fill_done), 0);
    chk({tag, "_idle_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_sync  = 1'b1;
    cmd_valid = 1'b0;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_pxl   = '0;
    ready     = 1'b0;
    repeat (3) @(negedge clk_ir);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_wr_valid", 32'(pxl_wr_valid), 0);
    chk("rst_rd_valid", 32'(pxl_rd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fill_done", 32'(fill_done), 0);
    chk("rst_posx", 32'(posx), 0);
    chk("rst_posy", 32'(posy), 0);
    chk("rst_pxl", 32'(pxl), 0);
    rst_sync = 1'b0;

    // single pixel
    ready = 1'b1;
    send(5, 7, 1, 1, 'hA5);
    chk("single_busy", 32'(busy), 1);
    pix("single", 5, 7, 'hA5);
    done_chk("single");

    // 3x2 raster order
    send(10, 20, 3, 2, 'h3C);
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 0; xx < 3; xx++)
        pix("r3x2", 10 + xx, 20 + yy, 'h3C);
    done_chk("r3x2");

    // backpressure: every pixel is held one cycle with ready low
    ready = 1'b0;
    send(0, 0, 4, 1, 'h5A);
    for (int k = 0; k < 4; k++) begin
      chk("bp_offer_valid", 32'(pxl_wr_valid), 1);
      chk("bp_offer_posx", 32'(posx), k);
      ready = 1'b0;
      @(negedge clk_ir);
      chk("bp_hold_valid", 32'(pxl_wr_valid), 1);
      chk("bp_hold_posx", 32'(posx), k);
      chk("bp_hold_posy", 32'(posy), 0);
      chk("bp_hold_pxl", 32'(pxl), 'h5A);
      ready = 1'b1;
      @(negedge clk_ir);
    end
    done_chk("bp");

    // empty rectangle goes straight to DONE
    send(3, 3, 0, 5, 'h11);
    done_chk("empty");

    // edge of canvas
    send(638, 479, 4, 3, 'h77);
`ifdef SYN_GPU_FILL_CLIP_EN
    pix("clip", 638, 479, 'h77);
    pix("clip", 639, 479, 'h77);
`else
    for (int yy = 0; yy < 3; yy++)
      for (int xx = 0; xx < 4; xx++)
        pix("noclip", 638 + xx, 479 + yy, 'h77);
`endif
    done_chk("edge");

    // reset in the middle of an 8x8 fill
    send(0, 0, 8, 8, 'hC3);
    for (int k = 0; k < 10; k++)
      pix("mid", k % 8, k / 8, 'hC3);
    chk("mid_pre_rst_posx", 32'(posx), 2);
    chk("mid_pre_rst_posy", 32'(posy), 1);
    rst_sync = 1'b1;
    @(negedge clk_ir);
    chk("mid_rst_wr_valid", 32'(pxl_wr_valid), 0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("mid_rst_done", 32'(fill_done), 0);
    chk("mid_rst_posx", 32'(posx), 0);
    rst_sync = 1'b0;
    @(negedge clk_ir);
    chk("mid_after_done", 32'(fill_done), 0);
    chk("mid_after_wr_valid", 32'(pxl_wr_valid), 0);
    chk("mid_after_cmd_ready", 32'(cmd_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
